// File: rtl/pcie_link_status_monitor.sv
// PCIe link status monitor: registers the LTSSM debug bus, drives status LEDs,
// tracks link state with a debounced FSM and keeps saturating link statistics.
module pcie_link_status_monitor #(
  parameter int LANES      = 1,
  parameter int ALIVE_BITS = 25,
  parameter int DEBOUNCE   = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk_out_buf,
  input  logic               any_rstn,
  input  logic [5+LANES-1:0] test_out_icm,
  input  logic               clr_stats,
  output logic               alive_led,
  output logic               L0_led,
  output logic               comp_led,
  output logic [LANES-1:0]   lane_active_led,
  output logic               link_up,
  output logic               link_down_sticky,
  output logic [CNT_W-1:0]   recovery_cnt,
  output logic [CNT_W-1:0]   ltssm_chg_cnt,
  output logic [1:0]         link_state
);

  localparam logic [4:0]       CODE_DETECT = 5'h00;
  localparam logic [4:0]       CODE_COMP   = 5'h03;
  localparam logic [4:0]       CODE_REC_LO = 5'h0C;
  localparam logic [4:0]       CODE_REC_HI = 5'h0E;
  localparam logic [4:0]       CODE_L0     = 5'h0F;
  localparam logic [7:0]       DEB_LAST    = 8'(DEBOUNCE - 1);
  localparam logic [7:0]       DEB_MAX     = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_DOWN    = 2'd0,
    ST_TRAIN   = 2'd1,
    ST_UP      = 2'd2,
    ST_RETRAIN = 2'd3
  } state_t;

  logic               rst_r;
  logic               rst_rr;
  logic [5+LANES-1:0] icm_q;
  logic [4:0]         code;
  logic [4:0]         code_prev;
  logic               is_l0;
  logic               is_rec;
  logic               code_chg;
  logic [ALIVE_BITS-1:0] alive_cnt;
  state_t             state_q;
  state_t             state_nxt;
  logic [7:0]         deb_q;
  logic [7:0]         deb_nxt;
  logic [7:0]         deb_inc;
  logic               rec_evt;
  logic               drop_evt;

  // Reset release is re-timed to clk_out_buf; assertion stays asynchronous.
  always_ff @(posedge clk_out_buf or negedge any_rstn) begin
    if (!any_rstn) begin
      rst_r  <= 1'b0;
      rst_rr <= 1'b0;
    end else begin
      rst_r  <= 1'b1;
      rst_rr <= rst_r;
    end
  end

  always_ff @(posedge clk_out_buf or negedge rst_rr) begin
    if (!rst_rr) begin
      icm_q     <= '0;
      code_prev <= '0;
    end else begin
      icm_q     <= test_out_icm;
      code_prev <= icm_q[4:0];
    end
  end

  assign code     = icm_q[4:0];
  assign is_l0    = (code == CODE_L0);
  assign is_rec   = (code >= CODE_REC_LO) && (code <= CODE_REC_HI);
  assign code_chg = (code != code_prev);

  always_ff @(posedge clk_out_buf or negedge rst_rr) begin
    if (!rst_rr) begin
      alive_cnt       <= '0;
      alive_led       <= 1'b0;
      L0_led          <= 1'b0;
      comp_led        <= 1'b0;
      lane_active_led <= '0;
    end else begin
      alive_cnt       <= alive_cnt + ALIVE_BITS'(1);
      alive_led       <= alive_cnt[ALIVE_BITS-1];
      L0_led          <= ~is_l0;
      comp_led        <= ~(code == CODE_COMP);
      lane_active_led <= ~icm_q[5+LANES-1:5];
    end
  end

  always_ff @(posedge clk_out_buf or negedge rst_rr) begin
    if (!rst_rr) begin
      state_q <= ST_DOWN;
      deb_q   <= '0;
    end else begin
      state_q <= state_nxt;
      deb_q   <= deb_nxt;
    end
  end

  // L0 cycles seen in DOWN already count toward the debounce window.
  assign deb_inc = is_l0 ? ((deb_q == DEB_MAX) ? deb_q : deb_q + 8'd1) : 8'd0;

  always_comb begin
    state_nxt = state_q;
    deb_nxt   = '0;
    rec_evt   = 1'b0;
    drop_evt  = 1'b0;
    case (state_q)
      ST_DOWN: begin
        deb_nxt = deb_inc;
        if (code != CODE_DETECT) begin
          state_nxt = ST_TRAIN;
        end
      end
      ST_TRAIN: begin
        deb_nxt = deb_inc;
        if (code == CODE_DETECT) begin
          state_nxt = ST_DOWN;
        end else if (is_l0 && (deb_q >= DEB_LAST)) begin
          state_nxt = ST_UP;
          deb_nxt   = '0;
        end
      end
      ST_UP: begin
        if (is_rec) begin
          state_nxt = ST_RETRAIN;
          rec_evt   = 1'b1;
        end else if (!is_l0) begin
          state_nxt = ST_DOWN;
          drop_evt  = 1'b1;
        end
      end
      ST_RETRAIN: begin
        if (is_l0) begin
          state_nxt = ST_UP;
        end else if (!is_rec) begin
          state_nxt = ST_DOWN;
          drop_evt  = 1'b1;
        end
      end
      default: state_nxt = ST_DOWN;
    endcase
  end

  always_comb begin
    link_up    = (state_q == ST_UP) || (state_q == ST_RETRAIN);
    link_state = state_q;
  end

  // A clear in the same cycle as an event wins; the event is lost.
  always_ff @(posedge clk_out_buf or negedge rst_rr) begin
    if (!rst_rr) begin
      recovery_cnt     <= '0;
      ltssm_chg_cnt    <= '0;
      link_down_sticky <= 1'b0;
    end else if (clr_stats) begin
      recovery_cnt     <= '0;
      ltssm_chg_cnt    <= '0;
      link_down_sticky <= 1'b0;
    end else begin
      if (rec_evt && (recovery_cnt != CNT_MAX)) begin
        recovery_cnt <= recovery_cnt + CNT_W'(1);
      end
      if (code_chg && (ltssm_chg_cnt != CNT_MAX)) begin
        ltssm_chg_cnt <= ltssm_chg_cnt + CNT_W'(1);
      end
      if (drop_evt) begin
        link_down_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_link_status_monitor.sv
// Directed bench for pcie_link_status_monitor in a 4-lane configuration with
// short heartbeat and statistics counters so wrap and saturation are reachable.
module tb_pcie_link_status_monitor;

  localparam int LANES      = 4;
  localparam int ALIVE_BITS = 3;
  localparam int DEBOUNCE   = 4;
  localparam int CNT_W      = 4;

  logic               clk_out_buf = 1'b0;
  logic               any_rstn;
  logic [5+LANES-1:0] test_out_icm;
  logic               clr_stats;
  logic               alive_led;
  logic               L0_led;
  logic               comp_led;
  logic [LANES-1:0]   lane_active_led;
  logic               link_up;
  logic               link_down_sticky;
  logic [CNT_W-1:0]   recovery_cnt;
  logic [CNT_W-1:0]   ltssm_chg_cnt;
  logic [1:0]         link_state;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] lanes  = 4'b0000;

  pcie_link_status_monitor #(
    .LANES      (LANES),
    .ALIVE_BITS (ALIVE_BITS),
    .DEBOUNCE   (DEBOUNCE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_out_buf      (clk_out_buf),
    .any_rstn         (any_rstn),
    .test_out_icm     (test_out_icm),
    .clr_stats        (clr_stats),
    .alive_led        (alive_led),
    .L0_led           (L0_led),
    .comp_led         (comp_led),
    .lane_active_led  (lane_active_led),
    .link_up          (link_up),
    .link_down_sticky (link_down_sticky),
    .recovery_cnt     (recovery_cnt),
    .ltssm_chg_cnt    (ltssm_chg_cnt),
    .link_state       (link_state)
  );

  always #5 clk_out_buf = ~clk_out_buf;

  task automatic tick();
    @(posedge clk_out_buf);
    #1;
  endtask

  task automatic apply_stimulus(input logic [4:0] code, input logic clr);
    test_out_icm = {lanes, code};
    clr_stats    = clr;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_alive"},  32'(alive_led),        32'd0);
    check_output({tag, "_l0"},     32'(L0_led),           32'd0);
    check_output({tag, "_comp"},   32'(comp_led),         32'd0);
    check_output({tag, "_lanes"},  32'(lane_active_led),  32'd0);
    check_output({tag, "_up"},     32'(link_up),          32'd0);
    check_output({tag, "_sticky"}, 32'(link_down_sticky), 32'd0);
    check_output({tag, "_rec"},    32'(recovery_cnt),     32'd0);
    check_output({tag, "_chg"},    32'(ltssm_chg_cnt),    32'd0);
    check_output({tag, "_state"},  32'(link_state),       32'd0);
  endtask

  initial begin
    int exp_state[7]  = '{0, 0, 0, 1, 1, 1, 2};
    int exp_train[9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 2};
    int exp_retrain[5] = '{2, 3, 3, 3, 2};

    $display("[TB] start");
    any_rstn = 1'b0;
    apply_stimulus(5'h0F, 1'b0);
    tick(); tick(); tick();
    check_all_zero("reset");

    // Release with L0 held: link_up must rise on the 7th edge after release.
    any_rstn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_output($sformatf("rel_state_e%0d", e), 32'(link_state), 32'(exp_state[e-1]));
      check_output($sformatf("rel_up_e%0d", e), 32'(link_up), 32'(e == 7));
      check_output($sformatf("rel_alive_e%0d", e), 32'(alive_led),
                   32'((e >= 3) && (((e - 3) % 8) >= 4)));
    end
    check_output("rel_l0_led",  32'(L0_led),          32'd0);
    check_output("rel_comp",    32'(comp_led),        32'd1);
    check_output("rel_lanes",   32'(lane_active_led), 32'hF);
    check_output("rel_chg_cnt", 32'(ltssm_chg_cnt),   32'd1);

    // Heartbeat with a 3-bit counter toggles every 4 cycles.
    for (int e = 8; e <= 15; e++) begin
      tick();
      check_output($sformatf("alive_e%0d", e), 32'(alive_led), 32'(((e - 3) % 8) >= 4));
      check_output($sformatf("up_state_e%0d", e), 32'(link_state), 32'd2);
    end

    lanes = 4'b0101;
    apply_stimulus(5'h0F, 1'b0);
    tick();
    check_output("lanes_latency", 32'(lane_active_led), 32'hF);
    tick();
    check_output("lanes_0101", 32'(lane_active_led), 32'hA);

    // Recovery excursion: 0x0C for three cycles, then back to L0.
    apply_stimulus(5'h0C, 1'b0);
    for (int t = 1; t <= 5; t++) begin
      if (t == 4) apply_stimulus(5'h0F, 1'b0);
      tick();
      check_output($sformatf("retrain_state_t%0d", t), 32'(link_state), 32'(exp_retrain[t-1]));
      check_output($sformatf("retrain_up_t%0d", t), 32'(link_up), 32'd1);
    end
    check_output("retrain_rec_cnt", 32'(recovery_cnt),  32'd1);
    check_output("retrain_chg_cnt", 32'(ltssm_chg_cnt), 32'd3);

    // Link loss from UP.
    apply_stimulus(5'h00, 1'b0);
    tick(); tick();
    check_output("drop_state",  32'(link_state),       32'd0);
    check_output("drop_up",     32'(link_up),          32'd0);
    check_output("drop_sticky", 32'(link_down_sticky), 32'd1);
    check_output("drop_l0_led", 32'(L0_led),           32'd1);
    check_output("drop_chg",    32'(ltssm_chg_cnt),    32'd4);

    apply_stimulus(5'h00, 1'b1);
    tick();
    apply_stimulus(5'h00, 1'b0);
    check_output("clr_sticky", 32'(link_down_sticky), 32'd0);
    check_output("clr_rec",    32'(recovery_cnt),     32'd0);
    check_output("clr_chg",    32'(ltssm_chg_cnt),    32'd0);
    check_output("clr_state",  32'(link_state),       32'd0);
    check_output("clr_lanes",  32'(lane_active_led),  32'hA);

    // Clear coinciding with a code-change event drops the event.
    apply_stimulus(5'h02, 1'b0);
    tick();
    apply_stimulus(5'h02, 1'b1);
    tick();
    apply_stimulus(5'h02, 1'b0);
    check_output("clr_wins_chg",   32'(ltssm_chg_cnt), 32'd0);
    check_output("clr_wins_state", 32'(link_state),    32'd1);

    // Alternating L0 / non-L0 in TRAIN never debounces; change count saturates.
    for (int k = 1; k <= 20; k++) begin
      apply_stimulus((k % 2 == 1) ? 5'h0F : 5'h02, 1'b0);
      tick();
      check_output($sformatf("alt_chg_k%0d", k), 32'(ltssm_chg_cnt),
                   32'((k - 1 > 15) ? 15 : k - 1));
      check_output($sformatf("alt_state_k%0d", k), 32'(link_state), 32'd1);
    end

    // A compliance code mid-debounce restarts the L0 count.
    for (int b = 1; b <= 9; b++) begin
      if (b == 1 || b == 5) apply_stimulus(5'h0F, 1'b0);
      if (b == 4) apply_stimulus(5'h03, 1'b0);
      tick();
      check_output($sformatf("deb_state_b%0d", b), 32'(link_state), 32'(exp_train[b-1]));
      if (b == 5) check_output("deb_comp_lit", 32'(comp_led), 32'd0);
      if (b == 6) check_output("deb_comp_off", 32'(comp_led), 32'd1);
    end

    // Asynchronous reset while in RETRAIN.
    apply_stimulus(5'h0D, 1'b0);
    tick(); tick();
    check_output("pre_rst_state", 32'(link_state),   32'd3);
    check_output("pre_rst_rec",   32'(recovery_cnt), 32'd1);
    #2;
    any_rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    any_rstn = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check_output($sformatf("resume_state_e%0d", e), 32'(link_state), 32'(e == 4));
      check_output($sformatf("resume_lanes_e%0d", e), 32'(lane_active_led),
                   (e <= 2) ? 32'h0 : ((e == 3) ? 32'hF : 32'hA));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
